// File: rtl/s2d_pkg.sv
// Shared types and constants for the stochastic-to-deterministic
// decision block.
package s2d_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam int CYC_W = 16;

   function automatic int midpoint(input int w);
      return 1 << (w - 1);
   endfunction

endpackage

// File: rtl/s2d_counter.sv
// Saturating up/down counter for one stochastic stream; dec is the
// MSB of the next count, i.e. next count >= midpoint.
module s2d_counter
   import s2d_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   input  logic q,
   output logic dec
);

   localparam logic [CNT_W-1:0] MID = CNT_W'(midpoint(CNT_W));
   localparam logic [CNT_W-1:0] TOP = '1;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (q && cnt != TOP)
         cnt_nxt = cnt + CNT_W'(1);
      else if (!q && cnt != '0)
         cnt_nxt = cnt - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= MID;
      else if (load)
         cnt <= MID;
      else if (en)
         cnt <= cnt_nxt;
   end

   assign dec = cnt_nxt[CNT_W-1];

endmodule

// File: rtl/s2d_decision.sv
// Decision block top: per-stream counters, decode-cycle FSM,
// stability-based convergence and cycle-budget timeout.
module s2d_decision
   import s2d_pkg::*;
#(
   parameter int N_VN    = 8,
   parameter int CNT_W   = 6,
   parameter int STABLE  = 16,
   parameter int MAX_CYC = 1000
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             INIT,
   input  logic [N_VN-1:0]  Q,
   output logic [N_VN-1:0]  HARD,
   output logic             BUSY,
   output logic             DONE,
   output logic             CONVERGED,
   output logic [CYC_W-1:0] CYCLES
);

   localparam logic [CYC_W-1:0] STABLE_V = CYC_W'(STABLE);
   localparam logic [CYC_W-1:0] MAX_V    = CYC_W'(MAX_CYC);

   state_t           state;
   state_t           state_nxt;
   logic [CYC_W-1:0] stable_cnt;
   logic [CYC_W-1:0] stable_nxt;
   logic [CYC_W-1:0] cyc_nxt;
   logic [N_VN-1:0]  hard_nxt;
   logic             go;
   logic             step;
   logic             hit_stable;
   logic             hit_max;

   assign go   = START && (state != ST_RUN);
   assign step = (state == ST_RUN) && !INIT;

   for (genvar i = 0; i < N_VN; i++) begin : g_cnt
      s2d_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk   (CLK),
         .rst_n (RST_N),
         .load  (go),
         .en    (step),
         .q     (Q[i]),
         .dec   (hard_nxt[i])
      );
   end

   always_comb begin
      cyc_nxt    = CYCLES + CYC_W'(1);
      stable_nxt = '0;
      if (hard_nxt == HARD)
         stable_nxt = (stable_cnt == STABLE_V) ? stable_cnt
                                               : stable_cnt + CYC_W'(1);
      hit_stable = (stable_nxt == STABLE_V);
      hit_max    = (cyc_nxt == MAX_V);
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (START) state_nxt = ST_RUN;
         ST_RUN:  if (step && (hit_stable || hit_max))
                     state_nxt = ST_DONE;
         ST_DONE: if (START) state_nxt = ST_RUN;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // CONVERGED tracks the stability hit each step; it only matters on exit
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         HARD       <= '0;
         CYCLES     <= '0;
         stable_cnt <= '0;
         CONVERGED  <= 1'b0;
      end else if (go) begin
         HARD       <= '1;
         CYCLES     <= '0;
         stable_cnt <= '0;
         CONVERGED  <= 1'b0;
      end else if (step) begin
         HARD       <= hard_nxt;
         CYCLES     <= cyc_nxt;
         stable_cnt <= stable_nxt;
         CONVERGED  <= hit_stable;
      end
   end

   assign BUSY = (state == ST_RUN);
   assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_s2d_decision.sv
// Directed bench for s2d_decision with a result scoreboard.
module tb_s2d_decision;

   typedef struct {
      logic [3:0] hard;
      int         cyc;
      logic       conv;
      int         edges;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start, init;
   logic [3:0]  q;
   logic [3:0]  hard;
   logic        busy, done, conv;
   logic [15:0] cycles;

   logic        start2, init2;
   logic [3:0]  q2;
   logic [3:0]  hard2;
   logic        busy2, done2, conv2;
   logic [15:0] cycles2;

   int checks   = 0;
   int failures = 0;

   exp_t sb[$];
   exp_t sb2[$];

   s2d_decision #(
      .N_VN(4), .CNT_W(4), .STABLE(4), .MAX_CYC(20)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .START(start), .INIT(init),
      .Q(q), .HARD(hard), .BUSY(busy), .DONE(done),
      .CONVERGED(conv), .CYCLES(cycles)
   );

   s2d_decision #(
      .N_VN(4), .CNT_W(4), .STABLE(30), .MAX_CYC(20)
   ) dut2 (
      .CLK(clk), .RST_N(rst_n), .START(start2), .INIT(init2),
      .Q(q2), .HARD(hard2), .BUSY(busy2), .DONE(done2),
      .CONVERGED(conv2), .CYCLES(cycles2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 32'(busy), 1);
      chk("start_done", 32'(done), 0);
      chk("start_cyc", 32'(cycles), 0);
      chk("start_hard", 32'(hard), 4'hF);
   endtask

   // mode 0: hold q, 1: alternate 0/F from 0, 2: 3 INIT cycles then F
   task automatic run1(input int mode);
      exp_t e;
      int   n;
      n = 0;
      while (!done && n < 60) begin
         if (mode == 1) q = n[0] ? 4'hF : 4'h0;
         if (mode == 2) begin
            init = (n < 3);
            q    = 4'hF;
         end
         @(negedge clk);
         n++;
         if (mode == 2 && n == 3)
            chk("init_hold_cyc", 32'(cycles), 0);
      end
      init = 1'b0;
      chk("done_seen", 32'(done), 1);
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("edges", 32'(n), 32'(e.edges));
         chk("end_busy", 32'(busy), 0);
         chk("end_hard", 32'(hard), 32'(e.hard));
         chk("end_cyc", 32'(cycles), 32'(e.cyc));
         chk("end_conv", 32'(conv), 32'(e.conv));
      end
   endtask

   initial begin
      exp_t e2;
      rst_n  = 1'b0;
      start  = 1'b0;
      init   = 1'b0;
      q      = 4'h0;
      start2 = 1'b0;
      init2  = 1'b0;
      q2     = 4'h0;
      repeat (2) @(negedge clk);
      chk("rst_hard", 32'(hard), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_cyc", 32'(cycles), 0);
      rst_n = 1'b1;

      q = 4'hF;
      sb.push_back('{4'hF, 4, 1'b1, 4});
      do_start();
      run1(0);

      q = 4'h0;
      sb.push_back('{4'h0, 5, 1'b1, 5});
      do_start();
      run1(0);

      sb.push_back('{4'hF, 20, 1'b0, 20});
      do_start();
      run1(1);

      sb.push_back('{4'hF, 4, 1'b1, 7});
      do_start();
      run1(2);

      q = 4'hF;
      do_start();
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_busy", 32'(busy), 0);
      chk("async_hard", 32'(hard), 0);
      chk("async_cyc", 32'(cycles), 0);
      chk("async_done", 32'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      sb2.push_back('{4'h0, 20, 1'b0, 20});
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int i = 0; i < 18; i++) begin
         q2 = (i < 10) ? 4'hF : 4'h0;
         @(negedge clk);
         if (i == 9) chk("sat_hard_hi", 32'(hard2), 4'hF);
         if (i == 16) begin
            chk("sat_hard_mid", 32'(hard2), 4'hF);
            chk("sat_cyc17", 32'(cycles2), 17);
         end
      end
      chk("sat_hard_lo", 32'(hard2), 4'h0);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      chk("run_start_busy", 32'(busy2), 1);
      chk("run_start_cyc", 32'(cycles2), 19);
      @(negedge clk);
      e2 = sb2.pop_front();
      chk("d2_done", 32'(done2), 1);
      chk("d2_conv", 32'(conv2), 32'(e2.conv));
      chk("d2_cyc", 32'(cycles2), 32'(e2.cyc));
      chk("d2_hard", 32'(hard2), 32'(e2.hard));
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      chk("restart_cyc", 32'(cycles2), 0);
      chk("restart_busy", 32'(busy2), 1);
      chk("restart_done", 32'(done2), 0);
      chk("restart_hard", 32'(hard2), 4'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/s2d_decision.md
# s2d_decision

Stochastic-to-deterministic decision block for the stochastic LDPC decoder. It consumes the per-variable stochastic output streams Q produced by the equality nodes and converts each stream into a hard-decision bit using a saturating up/down counter. It also runs the decode-cycle controller: start and done handshake, per-cycle counting, a convergence test on decision stability, and a cycle-budget timeout. It sits on the EN output side, opposite the deterministic-to-stochastic channel converters that feed `c`.

## Interface
Parameters:
- N_VN, 8: number of equality-node streams decided in parallel.
- CNT_W, 6: width of each per-stream up/down counter; midpoint M = 2^(CNT_W-1).
- STABLE, 16: number of consecutive unchanged decision vectors required to declare convergence (1..65535).
- MAX_CYC, 1000: decoding-cycle budget (1..65535).

Ports:
- CLK  in  1  decoder clock, same domain as CLK_D2S; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request a new decode; sampled only in IDLE or DONE.
- INIT  in  1  EN edge-memory initialization phase; freezes counting while high.
- Q  in  N_VN  stochastic output bits from the equality nodes.
- HARD  out  N_VN  registered hard decisions.
- BUSY  out  1  high in RUN.
- DONE  out  1  high in DONE until the next START.
- CONVERGED  out  1  valid while DONE; 1 means exit on stability, 0 means timeout.
- CYCLES  out  16  number of counted RUN cycles in the current or last decode.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- Transitions:
  - IDLE and START → RUN.
  - DONE and START → RUN (restart).
  - START is ignored in RUN.
- On entering RUN (the START edge):
  - every counter loads M;
  - HARD loads all ones;
  - CYCLES, the stable count and CONVERGED clear to 0;
  - DONE clears to 0.
- Each RUN edge with INIT=0 (a counted cycle):
  - counter[i] += 1 if Q[i]=1 and counter < 2^CNT_W-1;
  - counter[i] -= 1 if Q[i]=0 and counter > 0;
  - saturation holds the counter at its limit, with no wrap;
  - HARD[i] ← (new counter[i] ≥ M);
  - CYCLES += 1.
- Stability test, applied to the new HARD vector against the previous HARD vector:
  - if they are equal, the stable count increments, saturating at STABLE;
  - otherwise the stable count resets to 0.
- Exit conditions, evaluated on the same edge:
  - stable count reaches STABLE → DONE with CONVERGED=1;
  - otherwise, CYCLES reaches MAX_CYC → DONE with CONVERGED=0;
  - if both occur on the same edge, convergence takes priority and CONVERGED=1.
- A RUN edge with INIT=1 leaves the counters, HARD, CYCLES and the stable count unchanged. This skips the channel-loading cycles.
- DONE state: HARD, CYCLES and CONVERGED hold; counters hold.
- Reset values: HARD=0, BUSY=0, DONE=0, CONVERGED=0, CYCLES=0, counters=M, stable count=0.
- Reset asserted mid-RUN aborts immediately to IDLE with the reset values above. No DONE pulse is produced.

## Timing
- START sampled high at edge k (in IDLE or DONE) → BUSY=1 and DONE=0 after edge k.
- The first Q sample is taken at edge k+1.
- HARD has a latency of one edge from Q: Q at edge j is reflected in HARD after edge j.
- Exit on edge j gives BUSY=0, DONE=1 and final HARD/CYCLES/CONVERGED, all visible after edge j in the same cycle.
- Minimum decode is STABLE counted cycles. Maximum is MAX_CYC counted cycles plus any INIT cycles.
- All outputs are registered; there is no combinational path from Q or START to any output.

## Structure
- Shared package `s2d_pkg`:
  - state enum {IDLE, RUN, DONE};
  - CYCLES width constant (16);
  - function for the counter midpoint.
- One sub-module, `s2d_counter`: a CNT_W-bit saturating up/down counter with load-midpoint, enable and an MSB-compare decision output. It is instantiated N_VN times by generate.
- The top level holds the FSM, the cycle counter, the stable counter and the HARD comparison.

## Test plan
Bench parameters: N_VN=4, CNT_W=4 (M=8), STABLE=4, MAX_CYC=20.
- Reset: RST_N low mid-simulation → HARD=0000, BUSY=0, DONE=0, CYCLES=0. With RST_N low asynchronously during RUN, BUSY drops without a clock edge.
- Q=1111 constant after START → counters reach 12, HARD=1111, DONE after 4 counted cycles, CONVERGED=1, CYCLES=4.
- Q=0000 constant → first cycle gives counters=7 and HARD=0000 (stable count 0), then 4 more cycles → DONE, CYCLES=5, CONVERGED=1, HARD=0000.
- Q alternating 0000/1111 starting with 0 → counters oscillate 7/8 and HARD toggles every cycle → timeout at CYCLES=20, CONVERGED=0.
- INIT high for 3 cycles after START, then Q=1111 → CYCLES counts only INIT=0 cycles; DONE at CYCLES=4, reached 7 edges after START.
- Q=1111 for 10 cycles with STABLE forced large (testcase override 30) → counters saturate at 15 with no wrap. Then Q=0000 for 7 cycles → counters=8, HARD=1111. START pulsed during RUN is ignored (CYCLES continues), and START in DONE restarts with CYCLES=0.
